// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART widths and transmit-buffer FSM state type
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT
    } txbuf_state_t;

endpackage

// File: rtl/uart_tx_buffer_if.sv
// rtl/uart_tx_buffer_if.sv - host write port and transmitter handshake of the tx buffer
interface uart_tx_buffer_if import uart_pkg::*; #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = UART_DATA_W
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              tx_done;
    logic              busy;
    logic              ovf;
    logic              ovf_clr;

    modport master (
        output wr_en, wr_data, tx_done, ovf_clr,
        input  full, empty, count, tx_start, tx_data, busy, ovf
    );

    modport slave (
        input  wr_en, wr_data, tx_done, ovf_clr,
        output full, empty, count, tx_start, tx_data, busy, ovf
    );

endinterface

// File: rtl/uart_tx_buffer_sync_fifo.sv
// rtl/uart_tx_buffer_sync_fifo.sv - circular FIFO with occupancy count, shared by tx and rx buffers
module sync_fifo import uart_pkg::*; #(
    parameter int  DEPTH  = 16,
    parameter int  DATA_W = UART_DATA_W,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    // A write while full is dropped outright, even if a pop frees a slot on the same edge.
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// rtl/uart_tx_buffer.sv - byte FIFO draining into the UART transmitter one frame at a time
// Optional sticky overflow flag enabled by defining UART_TXBUF_OVF_EN.
module uart_tx_buffer import uart_pkg::*; #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = UART_DATA_W
) (
    input logic              clk,
    input logic              rst,
    uart_tx_buffer_if.slave  bus
);

    txbuf_state_t      state;
    logic [DATA_W-1:0] head;
    logic              fifo_empty;
    logic              pop;

    assign pop       = (state == IDLE) && !fifo_empty;
    assign bus.empty = fifo_empty;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.wr_en),
        .wr_data (bus.wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (bus.full),
        .empty   (fifo_empty),
        .count   (bus.count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bus.tx_start <= 1'b0;
            bus.tx_data  <= '0;
            bus.busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        bus.tx_data  <= head;
                        bus.tx_start <= 1'b1;
                        bus.busy     <= 1'b1;
                        state        <= START;
                    end
                end
                START: begin
                    bus.tx_start <= 1'b0;
                    state        <= WAIT;
                end
                WAIT: begin
                    if (bus.tx_done) begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    bus.tx_start <= 1'b0;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_TXBUF_OVF_EN
    // Set has priority so an overflow coinciding with a clear is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ovf <= 1'b0;
        end else if (bus.wr_en && bus.full) begin
            bus.ovf <= 1'b1;
        end else if (bus.ovf_clr) begin
            bus.ovf <= 1'b0;
        end
    end
`else
    logic ovf_clr_unused;
    assign ovf_clr_unused = bus.ovf_clr;
    assign bus.ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb/tb_uart_tx_buffer.sv - directed self-checking bench for uart_tx_buffer
module tb_uart_tx_buffer;
    import uart_pkg::*;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 8;
`ifdef UART_TXBUF_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic model_done = 1'b0;
    logic spur_done = 1'b0;
    logic stall = 1'b0;
    int   tx_cycles = 10;
    int   stab_err = 0;
    logic [7:0] rx_q[$];
    int   start_cyc[$];
    int   done_cyc[$];

    uart_tx_buffer_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus();

    uart_tx_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.tx_done = model_done | spur_done;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Transmitter model: records each started byte, checks tx_data holds, answers after tx_cycles.
    initial begin : tx_model
        logic       inflight;
        logic [7:0] cur;
        int         remain;
        inflight = 1'b0;
        cur = '0;
        remain = 0;
        forever begin
            @(negedge clk);
            model_done = 1'b0;
            if (rst) begin
                inflight = 1'b0;
            end else if (bus.tx_start) begin
                inflight = 1'b1;
                cur = bus.tx_data;
                rx_q.push_back(cur);
                start_cyc.push_back(cyc);
                remain = tx_cycles;
            end else if (inflight) begin
                if (bus.tx_data !== cur) stab_err++;
                if (!stall) begin
                    remain--;
                    if (remain <= 0) begin
                        model_done = 1'b1;
                        done_cyc.push_back(cyc);
                        inflight = 1'b0;
                    end
                end
            end
        end
    end

    task automatic push_byte(input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((bus.busy || !bus.empty) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, (bus.busy || !bus.empty) ? 32'd0 : 32'd1, 32'd1);
    endtask

    task automatic clear_logs();
        rx_q.delete();
        start_cyc.delete();
        done_cyc.delete();
        stab_err = 0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        int maxc;
        int idx;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.ovf_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_tx_start", bus.tx_start, 0);
        check_eq("rst_tx_data", bus.tx_data, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_count", bus.count, 0);
        check_eq("rst_empty", bus.empty, 1);
        check_eq("rst_full", bus.full, 0);
        check_eq("rst_ovf", bus.ovf, 0);

        // Single byte latency
        push_byte(8'hA5);
        check_eq("t1_count_e0", bus.count, 1);
        check_eq("t1_empty_e0", bus.empty, 0);
        check_eq("t1_start_e0", bus.tx_start, 0);
        @(negedge clk);
        check_eq("t1_start_e1", bus.tx_start, 1);
        check_eq("t1_data_e1", bus.tx_data, 8'hA5);
        check_eq("t1_busy_e1", bus.busy, 1);
        check_eq("t1_empty_e1", bus.empty, 1);
        @(negedge clk);
        check_eq("t1_start_e2", bus.tx_start, 0);
        check_eq("t1_busy_e2", bus.busy, 1);
        n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("t1_busy_drop", bus.busy, 0);
        check_eq("t1_done_seen", done_cyc.size(), 1);
        if (done_cyc.size() == 1) check_eq("t1_busy_lag", cyc - done_cyc[0], 1);
        check_eq("t1_rx_n", rx_q.size(), 1);
        check_eq("t1_rx0", (rx_q.size() > 0) ? rx_q[0] : 8'h00, 8'hA5);

        // Back-to-back bytes
        clear_logs();
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        wait_drain("t2_drain", 200);
        check_eq("t2_rx_n", rx_q.size(), 3);
        for (int i = 0; i < 3 && i < rx_q.size(); i++)
            check_eq($sformatf("t2_rx%0d", i), rx_q[i], i + 1);
        check_eq("t2_stable", stab_err, 0);
        for (int i = 1; i < 3 && i < start_cyc.size() && i <= done_cyc.size(); i++)
            check_eq($sformatf("t2_gap%0d", i), start_cyc[i] - done_cyc[i-1] + 1, 3);

        // Fill with stalled transmitter, overflow and clear
        clear_logs();
        stall = 1'b1;
        for (int i = 0; i < 17; i++) push_byte(8'(8'h40 + i));
        check_eq("t3_count", bus.count, 16);
        check_eq("t3_full", bus.full, 1);
        check_eq("t3_ovf_pre", bus.ovf, 0);
        check_eq("t3_inflight", bus.tx_data, 8'h40);
        push_byte(8'h99);
        check_eq("t3_count_drop", bus.count, 16);
        check_eq("t3_ovf", bus.ovf, OVF_EXP);
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        check_eq("t3_ovf_clr", bus.ovf, 0);
        bus.ovf_clr = 1'b1;
        push_byte(8'h98);
        bus.ovf_clr = 1'b0;
        check_eq("t3_ovf_setwins", bus.ovf, OVF_EXP);
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        check_eq("t3_ovf_clr2", bus.ovf, 0);
        stall = 1'b0;
        wait_drain("t3_drain", 600);
        check_eq("t3_rx_n", rx_q.size(), 17);
        for (int i = 0; i < 17 && i < rx_q.size(); i++)
            check_eq($sformatf("t3_rx%0d", i), rx_q[i], 8'h40 + i);

        // Wrap-around with 40 incrementing bytes
        clear_logs();
        idx = 0;
        maxc = 0;
        n = 0;
        while ((idx < 40 || bus.busy || !bus.empty) && n < 3000) begin
            if (int'(bus.count) > maxc) maxc = int'(bus.count);
            if (idx < 40 && !bus.full) begin
                bus.wr_en   = 1'b1;
                bus.wr_data = 8'(idx + 1);
                idx++;
            end else begin
                bus.wr_en = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bus.wr_en = 1'b0;
        check_eq("t4_done", (n < 3000) ? 1 : 0, 1);
        check_eq("t4_maxcount", maxc, 16);
        check_eq("t4_rx_n", rx_q.size(), 40);
        for (int i = 0; i < 40 && i < rx_q.size(); i++)
            check_eq($sformatf("t4_rx%0d", i), rx_q[i], i + 1);
        check_eq("t4_stable", stab_err, 0);

        // Reset while waiting with 5 bytes queued
        clear_logs();
        stall = 1'b1;
        for (int i = 0; i < 6; i++) push_byte(8'(8'h11 + i));
        repeat (3) @(negedge clk);
        check_eq("t5_pre_count", bus.count, 5);
        check_eq("t5_pre_busy", bus.busy, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("t5_tx_start", bus.tx_start, 0);
        check_eq("t5_tx_data", bus.tx_data, 0);
        check_eq("t5_busy", bus.busy, 0);
        check_eq("t5_count", bus.count, 0);
        check_eq("t5_empty", bus.empty, 1);
        check_eq("t5_full", bus.full, 0);
        check_eq("t5_ovf", bus.ovf, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        stall = 1'b0;
        clear_logs();
        push_byte(8'h3C);
        wait_drain("t5_drain", 100);
        check_eq("t5_rx_n", rx_q.size(), 1);
        check_eq("t5_rx0", (rx_q.size() > 0) ? rx_q[0] : 8'h00, 8'h3C);

        // Spurious tx_done in IDLE
        n = rx_q.size();
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        check_eq("t6_start0", bus.tx_start, 0);
        check_eq("t6_busy0", bus.busy, 0);
        @(negedge clk);
        check_eq("t6_start1", bus.tx_start, 0);
        check_eq("t6_busy1", bus.busy, 0);
        check_eq("t6_rx_n", rx_q.size(), n);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffer.md
# uart_tx_buffer

Transmit-side byte buffer feeding the UART transmitter. Accepts bytes from a host-side write port into a circular FIFO, then drains them one at a time into the transmitter through its `tx_start`/`tx_data`/`tx_done` handshake. Lets software or upstream logic burst up to DEPTH bytes without waiting on the serial line rate.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `DATA_W`, 8: byte width; must equal the transmitter data width.

- `clk` input 1: single clock for the whole block.
- `rst` input 1: reset, asynchronous, active-high.
- `wr_en` input 1: write strobe; `wr_data` is pushed when `wr_en && !full`.
- `wr_data` input DATA_W: byte to enqueue.
- `full` output 1: FIFO holds DEPTH entries.
- `empty` output 1: FIFO holds 0 entries.
- `count` output $clog2(DEPTH+1): current occupancy.
- `tx_start` output 1: one-cycle pulse to the transmitter.
- `tx_data` output DATA_W: byte to the transmitter; stable from `tx_start` until `tx_done`.
- `tx_done` input 1: one-cycle completion pulse from the transmitter.
- `busy` output 1: a byte is in flight, i.e. state is not IDLE.
- `ovf` output 1: sticky overflow flag (see Configuration).
- `ovf_clr` input 1: clears `ovf`.

## Operation
- Storage: DEPTH×DATA_W array, read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, and an occupancy counter. `full` and `empty` are decoded from the registered count.
- Push: on an edge where `wr_en && !full`, write `wr_data` at the write pointer, advance the pointer, and increment count.
- Write while `full`: the write is dropped. Storage and pointers are unchanged, even if a pop occurs on the same edge.
- FSM states:
  - IDLE: if `!empty`, load the head into the `tx_data` register, advance the read pointer, decrement count, and go to START.
  - START: assert `tx_start` for exactly this cycle, then go to WAIT.
  - WAIT: hold `tx_data`. On `tx_done`, go to IDLE.
- Push and pop on the same edge: count is unchanged and both pointers advance.
- `tx_done` in IDLE or START is ignored.
- Reset values: `tx_start`=0, `tx_data`=0, `busy`=0, `ovf`=0, `count`=0, `empty`=1, `full`=0, pointers=0, state=IDLE.
- Reset mid-operation: queued and in-flight bytes are discarded. The state of the downstream transmitter is not this block's concern.

## Timing
- Write sampled at edge E0. The pop happens at E1. `tx_start` is high between E1 and E2. WAIT is entered at E2.
- `tx_data` is valid from E1 and held until the edge after `tx_done`.
- Back-to-back bytes: the edge that samples `tx_done` returns to IDLE, and the next pop occurs on the following edge. This gives 3 cycles from `tx_done` to the next `tx_start`, a fixed overhead that is negligible at baud rates.
- `count`, `full`, `empty` reflect pushes and pops one edge after they occur.
- Throughput: one byte per transmitter frame. The FIFO accepts one write per cycle while not full.

## Configuration
- `UART_TXBUF_OVF_EN` defined:
  - `ovf` sets on any edge with `wr_en && full`.
  - `ovf` stays set until `ovf_clr` is sampled high.
  - If set and clear occur on the same edge, set wins.
- Not defined: `ovf` is tied 0 and `ovf_clr` is ignored. No flag register is synthesised.

## Structure
- Package `uart_pkg`:
  - `typedef enum logic [1:0] {IDLE, START, WAIT} txbuf_state_t`
  - `localparam UART_DATA_W = 8` shared with the transmitter and receiver.
- One sub-module: `sync_fifo`, holding storage, pointers, count, full and empty. It is parameterised by DEPTH and DATA_W and reusable on the receive side.
- `uart_tx_buffer` itself holds only the FSM, the `tx_data` register and the overflow flag.

## Test plan
- Reset, then write 0xA5 → `tx_start` pulses at E1 with `tx_data`=0xA5. `busy`=1 until one edge after a model `tx_done`. `empty`=1 from E1.
- Write 0x01..0x03 back-to-back with the transmitter model taking 10 cycles per byte → three `tx_start` pulses in order 0x01, 0x02, 0x03. Each `tx_data` is stable through its `tx_done`. The `tx_done`→`tx_start` gap is 3 cycles.
- With the transmitter model stalled (no `tx_done`), write 17 bytes at DEPTH=16:
  - byte 0 goes in flight;
  - bytes 1–16 fill the FIFO and `full`=1;
  - the 18th write is dropped and `ovf`=1 with the macro, 0 without;
  - `ovf_clr` clears the flag.
- Wrap-around: push and drain 40 bytes with incrementing values → output order is exact and `count` never exceeds 16.
- Assert `rst` while in WAIT with 5 bytes queued → all outputs return to reset values immediately. A subsequent write of 0x3C is the next byte transmitted.
- Spurious `tx_done` in IDLE → no state change, no `tx_start`.
